// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings, oversample constants, default divider.
// Kept separate so the future uart_tx can import the same encodings.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  localparam int          OS_RATE      = 16;
  localparam logic [3:0]  OS_MID       = 4'd7;
  localparam logic [3:0]  OS_SAMPLE    = 4'(OS_RATE - 1);
  localparam int          BAUD_DIV_DEF = 33;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider: counts 0..BAUD_DIV-1 and emits a one-cycle tick on the wrap cycle.
// One tick equals 1/16 of a bit period.
module uart_baud_gen
  import uart_rx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic osc_clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(BAUD_DIV - 1));
  assign tick   = w_wrap;

  always_ff @(posedge osc_clk) begin
    if (rst)         r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver, 8 data bits, LSB first, one stop bit.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       osc_clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  uart_state_e r_state, w_state_nxt;

  logic       r_sync1, r_sync2, r_rx_prev;
  logic [3:0] r_os;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_frame_err;
  logic       r_valid;
  logic       w_rx, w_fall, w_tick, w_sample;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud_gen (
    .osc_clk (osc_clk),
    .rst     (rst),
    .tick    (w_tick)
  );

  assign w_rx     = r_sync2;
  assign w_fall   = r_rx_prev & ~w_rx;
  assign w_sample = w_tick && (r_os == OS_SAMPLE);

  always_ff @(posedge osc_clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rxd;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  always_ff @(posedge osc_clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_fall) w_state_nxt = ST_START;
      ST_START: if (w_tick && (r_os == OS_MID)) w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (w_sample && (r_bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (w_sample) w_state_nxt = ST_STOP;
`endif
      // Stop sampled low means the line is held in break; wait for it to release.
      ST_STOP:  if (w_sample) w_state_nxt = w_rx ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (w_rx) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
`endif

  always_ff @(posedge osc_clk) begin
    if (rst) begin
      r_os        <= 4'd0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_frame_err <= 1'b0;
      r_valid     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_os      <= 4'd0;
          r_bit_cnt <= 3'd0;
        end
        ST_START: if (w_tick) r_os <= (r_os == OS_MID) ? 4'd0 : r_os + 4'd1;
        ST_DATA: begin
          if (w_tick) r_os <= r_os + 4'd1;
          if (w_sample) begin
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_tick)   r_os      <= r_os + 4'd1;
          if (w_sample) r_par_bit <= w_rx;
        end
`endif
        ST_STOP: begin
          if (w_tick) r_os <= r_os + 4'd1;
          if (w_sample) begin
            r_data      <= r_shift;
            r_frame_err <= ~w_rx;
            r_valid     <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= (^r_shift) ^ r_par_bit;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
// Compile with UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;

  localparam int BD      = 4;
  localparam int BIT_CYC = 16 * BD;

  logic       osc_clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  always #5 osc_clk = ~osc_clk;

  uart_rx #(.BAUD_DIV(BD)) dut (
    .osc_clk    (osc_clk),
    .rst        (rst),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int width_err = 0;
  int last_valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];

  always @(posedge osc_clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge osc_clk) begin
    if (valid) begin
      obs_q.push_back({parity_err, frame_err, data});
      last_valid_cyc = cyc;
      if (prev_valid) width_err++;
    end
    prev_valid = valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BIT_CYC) @(posedge osc_clk);
    #1;
  endtask

  function automatic logic model_pe(input logic [7:0] b, input logic pbit);
`ifdef UART_RX_PARITY_EN
    return (^b) ^ pbit;
`else
    return 1'b0;
`endif
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b,
                            input bit expect_strobe);
    if (expect_strobe) exp_q.push_back({model_pe(b, par_b), ~stop_b, b});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`endif
    drive_bit(stop_b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000; i++) begin
      if (!busy) break;
      @(posedge osc_clk);
      #1;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    wait_idle();
    repeat (4) @(posedge osc_clk);
    #1;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int t0, lat;
    logic [7:0] d_before, b;
    logic sb, pb;

    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge osc_clk);
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2 * BIT_CYC) @(posedge osc_clk);
    #1;

    // Single good frame with latency measurement.
    t0 = cyc;
    send_frame(8'h55, 1'b1, ^8'h55, 1'b1);
    drain("f55");
    lat = last_valid_cyc - t0;
`ifdef UART_RX_PARITY_EN
    lat = lat - BIT_CYC;
`endif
    chk("latency_window", {31'd0, (lat >= 607 && lat <= 615)}, 32'd1);

    // Short low glitch on the idle line.
    d_before = data;
    rxd = 1'b0;
    repeat (3 * BD) @(posedge osc_clk);
    #1;
    rxd = 1'b1;
    repeat (20 * BD) @(posedge osc_clk);
    #1;
    chk("glitch_no_strobe", obs_q.size(), 0);
    chk("glitch_busy", busy, 0);
    chk("glitch_data_held", data, d_before);

    // Bad stop bit followed by a held-low break, then a normal frame.
    send_frame(8'hA3, 1'b0, ^8'hA3, 1'b1);
    repeat (40 * BD) @(posedge osc_clk);
    #1;
    chk("break_one_strobe", obs_q.size(), 1);
    chk("break_busy", busy, 1);
    rxd = 1'b1;
    repeat (BIT_CYC) @(posedge osc_clk);
    #1;
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b1);
    drain("brk");

    // Reset after the 4th data bit; remaining bits are ones so the line stays high.
    b = {4'hF, 4'($urandom_range(0, 15))};
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rxd = 1'b1;
    @(posedge osc_clk);
    #1;
    rst = 1'b1;
    @(posedge osc_clk);
    #1;
    rst = 1'b0;
    chk("midrst_data", data, 8'h00);
    chk("midrst_valid", valid, 0);
    chk("midrst_ferr", frame_err, 0);
    chk("midrst_perr", parity_err, 0);
    chk("midrst_busy", busy, 0);
    repeat (6 * BIT_CYC) @(posedge osc_clk);
    #1;
    chk("midrst_no_strobe", obs_q.size(), 0);
    send_frame(8'hF0, 1'b1, ^8'hF0, 1'b1);
    drain("after_rst");

    // Back-to-back frames, no idle gap.
    send_frame(8'h01, 1'b1, ^8'h01, 1'b1);
    send_frame(8'hFF, 1'b1, ^8'hFF, 1'b1);
    send_frame(8'h80, 1'b1, ^8'h80, 1'b1);
    drain("b2b");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    drain("parity");
`endif

    // Random frames: mostly good stop bits, occasional framing errors and gaps.
    for (int k = 0; k < 12; k++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      pb = ($urandom_range(0, 1) == 1);
      send_frame(b, sb, pb, 1'b1);
      if (!sb) begin
        drive_bit(1'b1);
        drive_bit(1'b1);
      end else begin
        repeat ($urandom_range(0, 2)) drive_bit(1'b1);
      end
    end
    drain("rand");

    chk("valid_width", width_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
